// File: rtl/expr_pipe_pkg.sv
// Shared types for the pipelined expression ALU: opcode enum, request record
// and the signature rotate helper.
package expr_pipe_pkg;

    localparam int OP_W    = 4;
    localparam int MAX_W   = 32;
    localparam int SIG_MAX = 64;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XNOR = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_ASHR = 4'd8,
        OP_LT   = 4'd9,
        OP_LE   = 4'd10,
        OP_EQ   = 4'd11,
        OP_LAND = 4'd12,
        OP_RXOR = 4'd13,
        OP_NEG  = 4'd14,
        OP_SEL  = 4'd15
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [MAX_W-1:0] a;
        logic             a_signed;
        logic [MAX_W-1:0] b;
        logic             b_signed;
    } req_t;

    // Rotate left by one inside the low n bits of v (upper bits of v must be 0).
    function automatic logic [SIG_MAX-1:0] rotl1(input logic [SIG_MAX-1:0] v,
                                                 input int unsigned n);
        logic [SIG_MAX-1:0] mask;
        mask = (SIG_MAX'(1) << n) - SIG_MAX'(1);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/expr_pipe_alu_eval.sv
// Combinational evaluator: one Verilog-semantics expression on W-bit operands
// with per-operand signedness; ctx_signed qualifies the sign flag of y.
module expr_eval_comb
    import expr_pipe_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic            a_signed,
    input  logic [W-1:0]    b,
    input  logic            b_signed,
    output logic [W-1:0]    y,
    output logic            ctx_signed
);

    logic ctx;

    always_comb begin
        ctx        = a_signed && b_signed;
        y          = '0;
        ctx_signed = ctx;
        unique case (op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XNOR: y = ~(a ^ b);
            OP_SHL: begin
                y          = a << b;
                ctx_signed = a_signed;
            end
            OP_SHR: begin
                y          = a >> b;
                ctx_signed = a_signed;
            end
            OP_ASHR: begin
                // kept as separate branches so the signed shift never sits in an unsigned expression
                if (a_signed) y = $signed(a) >>> b;
                else          y = a >> b;
                ctx_signed = a_signed;
            end
            OP_LT: begin
                if (ctx) y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
                else     y = {{(W-1){1'b0}}, (a < b)};
                ctx_signed = 1'b0;
            end
            OP_LE: begin
                if (ctx) y = {{(W-1){1'b0}}, ($signed(a) <= $signed(b))};
                else     y = {{(W-1){1'b0}}, (a <= b)};
                ctx_signed = 1'b0;
            end
            OP_EQ: begin
                y          = {{(W-1){1'b0}}, (a == b)};
                ctx_signed = 1'b0;
            end
            OP_LAND: begin
                y          = {{(W-1){1'b0}}, ((a != '0) && (b != '0))};
                ctx_signed = 1'b0;
            end
            OP_RXOR: begin
                y          = {{(W-1){1'b0}}, (^a)};
                ctx_signed = 1'b0;
            end
            OP_NEG: begin
                y          = -a;
                ctx_signed = a_signed;
            end
            OP_SEL:  y = (a != '0) ? b : ~b;
        endcase
    end

endmodule

// File: rtl/expr_pipe_alu.sv
// Elastic DEPTH-stage expression pipeline with a running output signature.
// Evaluation happens at accept; later stages only carry the registered result.
module expr_pipe_alu
    import expr_pipe_pkg::*;
#(
    parameter int W     = 6,
    parameter int DEPTH = 2,
    parameter int SIGW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic            a_signed,
    input  logic [W-1:0]    b,
    input  logic            b_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic            y_zero,
    output logic            y_neg,
    input  logic            sig_clr,
    output logic [SIGW-1:0] sig,
    output logic [15:0]     count
);

    logic [W-1:0]    ev_y;
    logic            ev_ctx;
    logic [DEPTH-1:0] stg_v;
    logic [W-1:0]    stg_y [DEPTH];
    logic            stg_z [DEPTH];
    logic            stg_n [DEPTH];
    logic            hs;
    logic [SIGW-1:0] sig_base;
    logic [SIGW-1:0] sig_rot;
    logic [15:0]     cnt_base;

    expr_eval_comb #(.W(W)) u_eval (
        .op         (op),
        .a          (a),
        .a_signed   (a_signed),
        .b          (b),
        .b_signed   (b_signed),
        .y          (ev_y),
        .ctx_signed (ev_ctx)
    );

    assign out_valid = stg_v[DEPTH-1];
    assign y         = stg_y[DEPTH-1];
    assign y_zero    = stg_z[DEPTH-1];
    assign y_neg     = stg_n[DEPTH-1];
    assign in_ready  = out_ready || !out_valid;
    assign hs        = out_valid && out_ready;

    // a coincident clear is applied before the handshake folds y in
    assign sig_base  = sig_clr ? '0 : sig;
    assign cnt_base  = sig_clr ? '0 : count;
    assign sig_rot   = SIGW'(rotl1(SIG_MAX'(sig_base), SIGW));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg_v[i] <= 1'b0;
                stg_y[i] <= '0;
                stg_z[i] <= 1'b0;
                stg_n[i] <= 1'b0;
            end
        end else if (in_ready) begin
            stg_v[0] <= in_valid;
            if (in_valid) begin
                stg_y[0] <= ev_y;
                stg_z[0] <= (ev_y == '0);
                stg_n[0] <= ev_ctx && ev_y[W-1];
            end
            for (int i = 1; i < DEPTH; i++) begin
                stg_v[i] <= stg_v[i-1];
                if (stg_v[i-1]) begin
                    stg_y[i] <= stg_y[i-1];
                    stg_z[i] <= stg_z[i-1];
                    stg_n[i] <= stg_n[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig   <= '0;
            count <= '0;
        end else if (hs) begin
            sig   <= sig_rot ^ SIGW'(y);
            count <= cnt_base + 16'd1;
        end else if (sig_clr) begin
            sig   <= '0;
            count <= '0;
        end
    end

endmodule

// File: tb/tb_expr_pipe_alu.sv
// Bench for expr_pipe_alu: directed vector table, handshake corner sequences
// and a randomized run scored against an arithmetic reference model.
module tb_expr_pipe_alu;
    import expr_pipe_pkg::*;

    localparam int W     = 6;
    localparam int DEPTH = 2;
    localparam int SIGW  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      op = 4'd0;
    logic [W-1:0]    a = '0;
    logic            a_signed = 1'b0;
    logic [W-1:0]    b = '0;
    logic            b_signed = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    y;
    logic            y_zero;
    logic            y_neg;
    logic            sig_clr = 1'b0;
    logic [SIGW-1:0] sig;
    logic [15:0]     count;

    expr_pipe_alu #(.W(W), .DEPTH(DEPTH), .SIGW(SIGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .a_signed(a_signed), .b(b), .b_signed(b_signed),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_zero(y_zero),
        .y_neg(y_neg), .sig_clr(sig_clr), .sig(sig), .count(count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] y;
        logic         neg;
    } exp_t;

    // Reference model: operands become integers per the signedness rules.
    function automatic exp_t model(input logic [3:0] mop, input logic [W-1:0] ma,
                                   input logic [W-1:0] mb, input logic mas, input logic mbs);
        longint ua, ub, sa, sb, va, vb, r;
        int     sh;
        bit     ctx;
        exp_t   e;
        ua  = longint'(ma);
        ub  = longint'(mb);
        sa  = (mas && ma[W-1]) ? ua - (longint'(1) << W) : ua;
        sb  = (mbs && mb[W-1]) ? ub - (longint'(1) << W) : ub;
        ctx = mas && mbs;
        va  = ctx ? sa : ua;
        vb  = ctx ? sb : ub;
        r   = 0;
        case (mop)
            4'd0:  r = va + vb;
            4'd1:  r = va - vb;
            4'd2:  r = va * vb;
            4'd3:  r = ua & ub;
            4'd4:  r = ua | ub;
            4'd5:  r = ~(ua ^ ub);
            4'd6:  r = (ub >= W) ? 0 : (ua << ub);
            4'd7:  r = (ub >= W) ? 0 : (ua >> ub);
            4'd8: begin
                if (mas) begin
                    sh = (ub >= W) ? W - 1 : int'(ub);
                    r  = sa >>> sh;
                end else begin
                    r = (ub >= W) ? 0 : (ua >> ub);
                end
            end
            4'd9:  r = (va < vb) ? 1 : 0;
            4'd10: r = (va <= vb) ? 1 : 0;
            4'd11: r = (ua == ub) ? 1 : 0;
            4'd12: r = (ua != 0 && ub != 0) ? 1 : 0;
            4'd13: r = longint'($countones(ma) % 2);
            4'd14: r = -sa;
            default: r = (ua != 0) ? ub : ~ub;
        endcase
        e.y = r[W-1:0];
        if (mop >= 4'd9 && mop <= 4'd13)               e.neg = 1'b0;
        else if (mop inside {4'd6, 4'd7, 4'd8, 4'd14}) e.neg = mas && e.y[W-1];
        else                                           e.neg = ctx && e.y[W-1];
        return e;
    endfunction

    // Scoreboard and signature model, sampled between edges.
    exp_t            q[$];
    logic [SIGW-1:0] msig = '0;
    logic [SIGW-1:0] mbase;
    logic [15:0]     mcnt = '0;
    logic            p_stall = 1'b0;
    logic [W-1:0]    p_y = '0;

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            q.delete();
            msig    = '0;
            mcnt    = '0;
            p_stall = 1'b0;
        end else begin
            chk("sig", 64'(sig), 64'(msig));
            chk("count", 64'(count), 64'(mcnt));
            if (p_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_y", 64'(y), 64'(p_y));
            end
            if (in_valid && in_ready) q.push_back(model(op, a, b, a_signed, b_signed));
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_output: got y=%0h expected no output", y);
                end else begin
                    e = q.pop_front();
                    chk("out_y", 64'(y), 64'(e.y));
                    chk("out_neg", 64'(y_neg), 64'(e.neg));
                    chk("out_zero", 64'(y_zero), 64'(e.y == '0));
                    mbase = sig_clr ? '0 : msig;
                    msig  = {mbase[SIGW-2:0], mbase[SIGW-1]} ^ SIGW'(e.y);
                    mcnt  = (sig_clr ? 16'd0 : mcnt) + 16'd1;
                end
            end else if (sig_clr) begin
                msig = '0;
                mcnt = '0;
            end
            p_stall = out_valid && !out_ready;
            p_y     = y;
        end
    end

    typedef struct {
        op_e          vop;
        logic [W-1:0] va;
        logic         vas;
        logic [W-1:0] vb;
        logic         vbs;
        logic [W-1:0] ey;
        logic         ez;
        logic         en;
    } vec_t;

    vec_t tbl[17];

    task automatic apply_one(input vec_t v, input bit clr_at_out, input string nm);
        int lat;
        @(negedge clk);
        op = v.vop; a = v.va; a_signed = v.vas; b = v.vb; b_signed = v.vbs;
        in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat <= 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(DEPTH));
        chk({nm, "_y"}, 64'(y), 64'(v.ey));
        chk({nm, "_zero"}, 64'(y_zero), 64'(v.ez));
        chk({nm, "_neg"}, 64'(y_neg), 64'(v.en));
        if (clr_at_out) sig_clr = 1'b1;
        @(negedge clk);
        sig_clr = 1'b0;
    endtask

    initial begin
        int   sent, c, out0;
        bit   saw_stall;
        vec_t v;

        tbl[0]  = '{OP_ADD,  6'h3D, 1'b1, 6'h05, 1'b1, 6'h02, 1'b0, 1'b0};
        tbl[1]  = '{OP_LT,   6'h3F, 1'b1, 6'h01, 1'b0, 6'h00, 1'b1, 1'b0};
        tbl[2]  = '{OP_LT,   6'h3F, 1'b1, 6'h01, 1'b1, 6'h01, 1'b0, 1'b0};
        tbl[3]  = '{OP_ASHR, 6'h20, 1'b1, 6'h02, 1'b0, 6'h38, 1'b0, 1'b1};
        tbl[4]  = '{OP_ASHR, 6'h20, 1'b0, 6'h02, 1'b0, 6'h08, 1'b0, 1'b0};
        tbl[5]  = '{OP_ASHR, 6'h20, 1'b1, 6'h09, 1'b0, 6'h3F, 1'b0, 1'b1};
        tbl[6]  = '{OP_SHL,  6'h01, 1'b0, 6'h06, 1'b0, 6'h00, 1'b1, 1'b0};
        tbl[7]  = '{OP_SHR,  6'h3F, 1'b0, 6'h3F, 1'b0, 6'h00, 1'b1, 1'b0};
        tbl[8]  = '{OP_SUB,  6'h00, 1'b1, 6'h01, 1'b1, 6'h3F, 1'b0, 1'b1};
        tbl[9]  = '{OP_MUL,  6'h07, 1'b0, 6'h09, 1'b0, 6'h3F, 1'b0, 1'b0};
        tbl[10] = '{OP_NEG,  6'h01, 1'b1, 6'h00, 1'b0, 6'h3F, 1'b0, 1'b1};
        tbl[11] = '{OP_RXOR, 6'h07, 1'b1, 6'h00, 1'b1, 6'h01, 1'b0, 1'b0};
        tbl[12] = '{OP_SEL,  6'h00, 1'b0, 6'h0A, 1'b0, 6'h35, 1'b0, 1'b0};
        tbl[13] = '{OP_LE,   6'h20, 1'b1, 6'h20, 1'b1, 6'h01, 1'b0, 1'b0};
        tbl[14] = '{OP_EQ,   6'h15, 1'b0, 6'h16, 1'b0, 6'h00, 1'b1, 1'b0};
        tbl[15] = '{OP_XNOR, 6'h0F, 1'b0, 6'h33, 1'b0, 6'h03, 1'b0, 1'b0};
        tbl[16] = '{OP_LAND, 6'h04, 1'b1, 6'h00, 1'b1, 6'h00, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_y_zero", 64'(y_zero), 64'd0);
        chk("rst_y_neg", 64'(y_neg), 64'd0);
        chk("rst_sig", 64'(sig), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 17; i++) apply_one(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // signature: y=1 then y=3, then a clear coincident with y=5
        @(negedge clk); sig_clr = 1'b1;
        @(negedge clk); sig_clr = 1'b0;
        chk("sigclr_sig", 64'(sig), 64'd0);
        chk("sigclr_count", 64'(count), 64'd0);
        v = '{OP_ADD, 6'h01, 1'b0, 6'h00, 1'b0, 6'h01, 1'b0, 1'b0};
        apply_one(v, 1'b0, "sig_y1");
        v = '{OP_ADD, 6'h01, 1'b0, 6'h02, 1'b0, 6'h03, 1'b0, 1'b0};
        apply_one(v, 1'b0, "sig_y3");
        chk("sig_after_1_3", 64'(sig), 64'h1);
        chk("count_after_1_3", 64'(count), 64'd2);
        v = '{OP_ADD, 6'h02, 1'b0, 6'h03, 1'b0, 6'h05, 1'b0, 1'b0};
        apply_one(v, 1'b1, "sig_y5");
        chk("sig_clr_coincident", 64'(sig), 64'h5);
        chk("count_clr_coincident", 64'(count), 64'd1);

        // backpressure: 6 ADDs, consumer stalled for cycles 3..7
        @(negedge clk); sig_clr = 1'b1;
        @(negedge clk); sig_clr = 1'b0;
        sent = 0; c = 0; saw_stall = 1'b0; out0 = n_out;
        while ((sent < 6 || n_out - out0 < 6) && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            in_valid  = (sent < 6);
            op = 4'(OP_ADD); a = W'(sent + 1); b = W'(sent + 1);
            a_signed = 1'b0; b_signed = 1'b0;
            #1;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_outputs", 64'(n_out - out0), 64'd6);
        chk("bp_count", 64'(count), 64'd6);

        // reset with two transactions in flight
        @(negedge clk);
        op = 4'(OP_ADD); a = 6'h01; b = 6'h01; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); a = 6'h02;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sig", 64'(sig), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        apply_one(tbl[0], 1'b0, "post_rst");

        // randomized traffic against the model
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            sig_clr   = ($urandom_range(0, 19) == 0);
            op        = 4'($urandom);
            a         = W'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W + 2)) : W'($urandom);
            a_signed  = 1'($urandom);
            b_signed  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; sig_clr = 1'b0;
        repeat (DEPTH + 4) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/expr_pipe_alu.md
Name: expr_pipe_alu

Overview:
- Parametrised, pipelined successor to the combinational mixed-signedness expression blocks.
- Evaluates one Verilog-semantics expression per transaction on W-bit operands with per-operand signedness and a runtime opcode.
- Uses an elastic valid/ready pipeline and keeps a running output signature so regression benches compare one 32-bit value against a golden model.

Parameters:
- W, 6, operand/result width (2..32)
- DEPTH, 2, register stages from input accept to output (1..4)
- SIGW, 32, signature width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid&&in_ready
- op  in  4  opcode (see Behaviour)
- a  in  W  operand A
- a_signed  in  1  A declared signed
- b  in  W  operand B
- b_signed  in  1  B declared signed
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- y  out  W  result
- y_zero  out  1  y==0
- y_neg  out  1  y[W-1] when result context signed, else 0
- sig_clr  in  1  synchronous signature clear
- sig  out  SIGW  running signature
- count  out  16  output handshakes since reset/sig_clr, wraps

Behaviour:
- Reset: out_valid=0, y=0, y_zero=0, y_neg=0, sig=0, count=0, all stage valids 0. in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight transactions.
- Context: signed iff a_signed && b_signed; otherwise both operands are zero-extended/unsigned (Verilog mixing rule).
- Exceptions: SHL/SHR/ASHR/RXOR/NEG take their signedness from a_signed alone; the shift amount b is always unsigned.
- Opcodes (result truncated to W bits):
  - 0 ADD
  - 1 SUB
  - 2 MUL (low W bits)
  - 3 AND
  - 4 OR
  - 5 XNOR
  - 6 SHL
  - 7 SHR (logical)
  - 8 ASHR (sign-fills only if a_signed)
  - 9 LT
  - 10 LE
  - 11 EQ
  - 12 LAND (a!=0 && b!=0)
  - 13 RXOR (^a)
  - 14 NEG (-a)
  - 15 SEL (a!=0 ? b : ~b)
- Boolean ops 9–13 return a 1-bit value zero-extended to W, and y_neg=0.
- Shift amount >= W: SHL/SHR give 0; ASHR gives all-sign-bits.
- Evaluation happens combinationally at accept and is registered into stage 1. Stages 2..DEPTH are plain registers.
- Latency is exactly DEPTH cycles from accept to out_valid when there is no backpressure.
- Handshake:
  - in_ready = out_ready || !out_valid; the whole pipeline shifts when in_ready=1.
  - Bubbles collapse only at the output stage.
  - in_ready is combinationally dependent on out_ready.
  - While out_valid=1 && out_ready=0: y, y_zero, y_neg and out_valid hold stable.
- Ordering: strictly in order, no drops, no duplicates.
- Signature on each output handshake: sig <= rotl1(sig) ^ zext(y); count <= count+1.
- sig_clr:
  - Clears sig and count to 0.
  - If it coincides with an output handshake, the clear applies first: sig=zext(y), count=1.
  - sig_clr does not affect the pipeline.

Decomposition:
- Package expr_pipe_pkg holds:
  - op_e enum (16 opcodes)
  - OP_W=4
  - a struct {op, a, a_signed, b, b_signed} parametrised via localparam width
  - a function rotl1
- One natural sub-module, expr_eval_comb: pure combinational evaluator (op, operands, signedness -> y, ctx_signed).
- The top holds the pipeline registers, handshake and signature logic.

Test Plan:
- ADD, W=6: a=6'h3D signed, b=6'h05 signed -> y=6'h02, y_neg=0, y_zero=0 after exactly 2 cycles (DEPTH=2).
- LT mixed: a=6'h3F, b=6'h01, a_signed=1, b_signed=0 -> y=0 (unsigned 63<1 false). Same with b_signed=1 -> y=1.
- ASHR: a=6'h20, b=2, a_signed=1 -> y=6'h38, y_neg=1. a_signed=0 -> y=6'h08. b=9, a_signed=1 -> y=6'h3F.
- Backpressure: stream 6 ADDs with out_ready=0 for cycles 3–7:
  - in_ready drops once both stages fill.
  - y holds stable while stalled.
  - All 6 results emerge in order, count=6.
- Signature: outputs y=1 then y=3 -> sig=32'h1. sig_clr coincident with the next output y=5 -> sig=32'h5, count=1.
- Reset mid-stream with 2 transactions in flight -> out_valid=0 and sig=0 on the next cycle, in_ready=1; the first new accept appears DEPTH cycles later.
